// File: rtl/brush_stamper.sv
// Brush stamper: accepts one brush request and sweeps its clipped bounding box one
// pixel per clock, emitting registered write strobes for the canvas pixel store.
module brush_stamper #(
  parameter int CANVAS_W = 200,
  parameter int CANVAS_H = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       ready,
  input  logic [7:0] cx,
  input  logic [7:0] cy,
  input  logic [2:0] radius,
  input  logic       round,
  input  logic [2:0] color,
  output logic       brush,
  output logic [7:0] wx,
  output logic [7:0] wy,
  output logic [2:0] newColor,
  output logic       done,
  output logic [1:0] o_dbg_state
);

  // Handshake: a request transfers on a rising edge where req && ready; ready is
  // high only in IDLE, and req is ignored whenever ready is low.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLIP = 2'd1, S_SWEEP = 2'd2} state_t;

  localparam logic signed [9:0] W_MAX = 10'(CANVAS_W - 1);
  localparam logic signed [9:0] H_MAX = 10'(CANVAS_H - 1);

  state_t r_state, w_next;

  logic [7:0] r_cx, r_cy, r_xs, r_xe, r_ye, r_x, r_y;
  logic [2:0] r_rad, r_color;
  logic       r_round, r_active;
  logic       r_brush, r_done;
  logic [7:0] r_wx, r_wy;
  logic [2:0] r_new_color;

  logic signed [9:0] w_cx_s, w_cy_s, w_r_s, w_xlo, w_xhi, w_ylo, w_yhi;
  logic [7:0] w_xs, w_xe, w_ys, w_ye;
  logic       w_empty, w_last;
  logic [2:0] w_adx, w_ady;
  logic [7:0] w_dist, w_lim;
  logic       w_inside;

  // Clip arithmetic is signed 10-bit so cx-r can go negative and cx+r can exceed 255.
  assign w_cx_s = signed'({2'b00, r_cx});
  assign w_cy_s = signed'({2'b00, r_cy});
  assign w_r_s  = signed'({7'b0000000, r_rad});
  assign w_xlo  = w_cx_s - w_r_s;
  assign w_xhi  = w_cx_s + w_r_s;
  assign w_ylo  = w_cy_s - w_r_s;
  assign w_yhi  = w_cy_s + w_r_s;
  assign w_xs   = (w_xlo < 10'sd0) ? 8'd0 : 8'(w_xlo);
  assign w_xe   = (w_xhi > W_MAX) ? 8'(W_MAX) : 8'(w_xhi);
  assign w_ys   = (w_ylo < 10'sd0) ? 8'd0 : 8'(w_ylo);
  assign w_ye   = (w_yhi > H_MAX) ? 8'(H_MAX) : 8'(w_yhi);
  assign w_empty = (w_cx_s > W_MAX) || (w_cy_s > H_MAX);

  // Offsets from the centre are bounded by the radius, so 3-bit magnitudes suffice.
  assign w_adx  = 3'((r_x >= r_cx) ? (r_x - r_cx) : (r_cx - r_x));
  assign w_ady  = 3'((r_y >= r_cy) ? (r_y - r_cy) : (r_cy - r_y));
  assign w_dist = ({5'd0, w_adx} * {5'd0, w_adx}) + ({5'd0, w_ady} * {5'd0, w_ady});
  assign w_lim  = ({5'd0, r_rad} * {5'd0, r_rad}) + {5'd0, r_rad};
  assign w_inside = !r_round || (w_dist <= w_lim);
  assign w_last   = (r_x == r_xe) && (r_y == r_ye);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req) w_next = S_CLIP;
      S_CLIP:  w_next = w_empty ? S_IDLE : S_SWEEP;
      S_SWEEP: if (!r_active) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // SWEEP runs one extra cycle after the last candidate so the registered outputs drain
  // before done is raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cx <= '0; r_cy <= '0; r_rad <= '0; r_round <= 1'b0; r_color <= '0;
      r_xs <= '0; r_xe <= '0; r_ye <= '0; r_x <= '0; r_y <= '0;
      r_active <= 1'b0;
      r_brush <= 1'b0; r_done <= 1'b0;
      r_wx <= '0; r_wy <= '0; r_new_color <= '0;
    end else begin
      r_brush <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_cx <= cx; r_cy <= cy; r_rad <= radius; r_round <= round; r_color <= color;
          end
        end
        S_CLIP: begin
          if (w_empty) begin
            r_done <= 1'b1;
          end else begin
            r_xs <= w_xs; r_xe <= w_xe; r_ye <= w_ye;
            r_x  <= w_xs; r_y  <= w_ys;
            r_active <= 1'b1;
          end
        end
        S_SWEEP: begin
          if (r_active) begin
            r_brush     <= w_inside;
            r_wx        <= r_x;
            r_wy        <= r_y;
            r_new_color <= r_color;
            if (w_last) begin
              r_active <= 1'b0;
            end else if (r_x == r_xe) begin
              r_x <= r_xs;
              r_y <= r_y + 8'd1;
            end else begin
              r_x <= r_x + 8'd1;
            end
          end else begin
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign brush       = r_brush;
  assign wx          = r_wx;
  assign wy          = r_wy;
  assign newColor    = r_new_color;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_brush_stamper.sv
// Directed bench for brush_stamper: each scenario task drives a request, captures the
// per-cycle outputs and compares them against hand-derived raster/shape expectations.
module tb_brush_stamper;

  logic       clk = 1'b0;
  logic       reset, req, round, ready, brush, done;
  logic [7:0] cx, cy, wx, wy;
  logic [2:0] radius, color, newColor;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  // Capture index j holds the outputs seen in the cycle after edge E(j), E0 = accept.
  logic       cap_brush [0:127];
  logic       cap_ready [0:127];
  logic [7:0] cap_wx    [0:127];
  logic [7:0] cap_wy    [0:127];
  logic [2:0] cap_col   [0:127];
  int         cap_done_idx;

  always #5 clk = ~clk;

  brush_stamper #(.CANVAS_W(200), .CANVAS_H(200)) dut (
    .clk(clk), .reset(reset), .req(req), .ready(ready),
    .cx(cx), .cy(cy), .radius(radius), .round(round), .color(color),
    .brush(brush), .wx(wx), .wy(wy), .newColor(newColor), .done(done),
    .o_dbg_state(dbg_state)
  );

  task automatic wait_ready();
    int guard = 0;
    while (ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL wait_ready: ready=%b required 1 within 200 cycles", ready);
    end
  endtask

  // Driver: issues one request at a negedge and captures outputs until done (bounded).
  // With noise set, req is pulsed with junk operands while the block is busy.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [2:0] r,
                      input logic rnd, input logic [2:0] c, input bit noise);
    for (int i = 0; i < 128; i++) begin
      cap_brush[i] = 1'bx; cap_ready[i] = 1'bx;
      cap_wx[i] = 'x; cap_wy[i] = 'x; cap_col[i] = 'x;
    end
    wait_ready();
    cx = x; cy = y; radius = r; round = rnd; color = c; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    cap_done_idx = -1;
    for (int j = 0; j < 128; j++) begin
      if (noise && j >= 1 && j <= 4) begin
        req = 1'b1; cx = 8'd0; cy = 8'd0; radius = 3'd7; color = 3'd0;
      end
      @(negedge clk);
      req = 1'b0;
      cap_brush[j] = brush; cap_ready[j] = ready;
      cap_wx[j] = wx; cap_wy[j] = wy; cap_col[j] = newColor;
      if (done === 1'b1) begin
        cap_done_idx = j;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b1; cx = 8'd1; cy = 8'd1; radius = 3'd1; round = 1'b0; color = 3'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (brush !== 1'b0)    begin bad++; $display("FAIL reset_brush: got %b exp 0", brush); end
    total++; if (wx !== 8'd0)       begin bad++; $display("FAIL reset_wx: got %0d exp 0", wx); end
    total++; if (wy !== 8'd0)       begin bad++; $display("FAIL reset_wy: got %0d exp 0", wy); end
    total++; if (newColor !== 3'd0) begin bad++; $display("FAIL reset_color: got %0d exp 0", newColor); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b exp 0", done); end
    total++; if (ready !== 1'b1)    begin bad++; $display("FAIL reset_ready: got %b exp 1", ready); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    req = 1'b0; reset = 1'b0;
  endtask

  task automatic test_single();
    int cnt = 0;
    send(8'd10, 8'd20, 3'd0, 1'b0, 3'd5, 1'b0);
    total++; if (cap_done_idx != 3) begin bad++; $display("FAIL single_done_idx: got %0d exp 3", cap_done_idx); end
    total++; if (cap_ready[0] !== 1'b0) begin bad++; $display("FAIL single_ready_busy: got %b exp 0", cap_ready[0]); end
    total++; if (cap_brush[2] !== 1'b1) begin bad++; $display("FAIL single_brush: got %b exp 1", cap_brush[2]); end
    total++; if (cap_wx[2] !== 8'd10)   begin bad++; $display("FAIL single_wx: got %0d exp 10", cap_wx[2]); end
    total++; if (cap_wy[2] !== 8'd20)   begin bad++; $display("FAIL single_wy: got %0d exp 20", cap_wy[2]); end
    total++; if (cap_col[2] !== 3'd5)   begin bad++; $display("FAIL single_color: got %0d exp 5", cap_col[2]); end
    for (int j = 0; j < 4; j++) if (cap_brush[j] === 1'b1) cnt++;
    total++; if (cnt != 1) begin bad++; $display("FAIL single_count: got %0d exp 1", cnt); end
    total++; if (cap_brush[3] !== 1'b0 || cap_ready[3] !== 1'b1) begin
      bad++; $display("FAIL single_done_cycle: brush=%b ready=%b exp brush=0 ready=1", cap_brush[3], cap_ready[3]);
    end
  endtask

  task automatic test_square();
    send(8'd100, 8'd100, 3'd2, 1'b0, 3'd3, 1'b0);
    total++; if (cap_done_idx != 27) begin bad++; $display("FAIL square_done_idx: got %0d exp 27", cap_done_idx); end
    for (int k = 0; k < 25; k++) begin
      total++;
      if (cap_brush[k+2] !== 1'b1 || cap_wx[k+2] !== 8'(98 + k % 5) || cap_wy[k+2] !== 8'(98 + k / 5)
          || cap_col[k+2] !== 3'd3) begin
        bad++;
        $display("FAIL square_k%0d: got brush=%b x=%0d y=%0d c=%0d exp 1 %0d %0d 3",
                 k, cap_brush[k+2], cap_wx[k+2], cap_wy[k+2], cap_col[k+2], 98 + k % 5, 98 + k / 5);
      end
    end
  endtask

  task automatic test_corner();
    send(8'd0, 8'd0, 3'd3, 1'b0, 3'd7, 1'b0);
    total++; if (cap_done_idx != 18) begin bad++; $display("FAIL corner_done_idx: got %0d exp 18", cap_done_idx); end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (cap_brush[k+2] !== 1'b1 || cap_wx[k+2] !== 8'(k % 4) || cap_wy[k+2] !== 8'(k / 4)) begin
        bad++;
        $display("FAIL corner_k%0d: got brush=%b x=%0d y=%0d exp 1 %0d %0d",
                 k, cap_brush[k+2], cap_wx[k+2], cap_wy[k+2], k % 4, k / 4);
      end
    end
  endtask

  task automatic test_disc();
    int cnt = 0;
    send(8'd50, 8'd50, 3'd2, 1'b1, 3'd2, 1'b0);
    total++; if (cap_done_idx != 27) begin bad++; $display("FAIL disc_done_idx: got %0d exp 27", cap_done_idx); end
    for (int k = 0; k < 25; k++) begin
      int  dx = k % 5 - 2;
      int  dy = k / 5 - 2;
      logic exp_in = (dx * dx + dy * dy) <= 6;
      if (cap_brush[k+2] === 1'b1) cnt++;
      total++;
      if (cap_brush[k+2] !== exp_in || cap_wx[k+2] !== 8'(48 + k % 5) || cap_wy[k+2] !== 8'(48 + k / 5)) begin
        bad++;
        $display("FAIL disc_k%0d: got brush=%b x=%0d y=%0d exp %b %0d %0d",
                 k, cap_brush[k+2], cap_wx[k+2], cap_wy[k+2], exp_in, 48 + k % 5, 48 + k / 5);
      end
    end
    total++; if (cnt != 21) begin bad++; $display("FAIL disc_count: got %0d exp 21", cnt); end
  endtask

  task automatic test_empty_and_busy();
    send(8'd210, 8'd5, 3'd1, 1'b0, 3'd6, 1'b0);
    total++; if (cap_done_idx != 1) begin bad++; $display("FAIL empty_done_idx: got %0d exp 1", cap_done_idx); end
    total++; if (cap_brush[0] !== 1'b0 || cap_brush[1] !== 1'b0) begin
      bad++; $display("FAIL empty_brush: got %b%b exp 00", cap_brush[0], cap_brush[1]);
    end
    total++; if (cap_ready[1] !== 1'b1) begin bad++; $display("FAIL empty_ready: got %b exp 1", cap_ready[1]); end
    send(8'd30, 8'd30, 3'd1, 1'b0, 3'd4, 1'b1);
    total++; if (cap_done_idx != 11) begin bad++; $display("FAIL busy_done_idx: got %0d exp 11", cap_done_idx); end
    total++; if (cap_wx[2] !== 8'd29 || cap_wy[2] !== 8'd29 || cap_col[2] !== 3'd4) begin
      bad++; $display("FAIL busy_first: got x=%0d y=%0d c=%0d exp 29 29 4", cap_wx[2], cap_wy[2], cap_col[2]);
    end
    total++; if (cap_wx[10] !== 8'd31 || cap_wy[10] !== 8'd31) begin
      bad++; $display("FAIL busy_last: got x=%0d y=%0d exp 31 31", cap_wx[10], cap_wy[10]);
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || ready !== 1'b1 || brush !== 1'b0) begin
        bad++; $display("FAIL busy_after%0d: done=%b ready=%b brush=%b exp 0 1 0", j, done, ready, brush);
      end
    end
  endtask

  task automatic test_back_to_back();
    send(8'd60, 8'd70, 3'd1, 1'b0, 3'd2, 1'b0);
    total++; if (cap_done_idx != 11) begin bad++; $display("FAIL b2b_first_done: got %0d exp 11", cap_done_idx); end
    send(8'd5, 8'd6, 3'd0, 1'b0, 3'd3, 1'b0);
    total++; if (cap_ready[0] !== 1'b0) begin bad++; $display("FAIL b2b_accept: ready=%b exp 0", cap_ready[0]); end
    total++; if (cap_done_idx != 3) begin bad++; $display("FAIL b2b_second_done: got %0d exp 3", cap_done_idx); end
    total++; if (cap_brush[2] !== 1'b1 || cap_wx[2] !== 8'd5 || cap_wy[2] !== 8'd6 || cap_col[2] !== 3'd3) begin
      bad++; $display("FAIL b2b_write: got b=%b x=%0d y=%0d c=%0d exp 1 5 6 3", cap_brush[2], cap_wx[2], cap_wy[2], cap_col[2]);
    end
  endtask

  task automatic test_reset_mid();
    wait_ready();
    cx = 8'd100; cy = 8'd100; radius = 3'd3; round = 1'b0; color = 3'd4; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (brush !== 1'b1 || wx !== 8'd100 || wy !== 8'd97) begin
      bad++; $display("FAIL mid_before: got b=%b x=%0d y=%0d exp 1 100 97", brush, wx, wy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (brush !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL mid_after_reset: b=%b ready=%b done=%b exp 0 1 0", brush, ready, done);
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      total++;
      if (brush !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL mid_quiet%0d: b=%b done=%b exp 0 0", j, brush, done);
      end
    end
    send(8'd7, 8'd8, 3'd0, 1'b0, 3'd1, 1'b0);
    total++; if (cap_done_idx != 3) begin bad++; $display("FAIL mid_next_done: got %0d exp 3", cap_done_idx); end
    total++; if (cap_brush[2] !== 1'b1 || cap_wx[2] !== 8'd7 || cap_wy[2] !== 8'd8) begin
      bad++; $display("FAIL mid_next_write: got b=%b x=%0d y=%0d exp 1 7 8", cap_brush[2], cap_wx[2], cap_wy[2]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_square();
    test_corner();
    test_disc();
    test_empty_and_busy();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
